time_set_ctrl: RTL and testbench

// - Button-driven time-entry controller; the writer side of the 12-hour clock's set interface.
// - Captures the running time, lets the user edit hour/min/sec with MODE/UP/DOWN, then commits.
// - Commit drives hour_set_o/min_set_o/sec_set_o and pulses timeset_o into the clock's Timeset/Hourset/Minset/Secset inputs.
// - Sits between board pushbuttons and the clock core; field_o feeds the display blink logic.

---
 rtl/time_set_ctrl.sv | 263 ++++++++++++++++++++++++++
 tb/tb_time_set_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/time_set_ctrl.sv
// time_set_ctrl: pushbutton time-entry controller that edits and commits hour/min/sec to the 12-hour clock core.
// Optional macro AUTOREPEAT_EN adds hold-to-repeat on UP/DOWN while editing.
module time_set_ctrl #(
    parameter int TICK_DIV      = 100000,
    parameter int DEBOUNCE_MS   = 20,
    parameter int TIMEOUT_MS    = 10000
`ifdef AUTOREPEAT_EN
    ,
    parameter int REPEAT_DLY_MS = 500,
    parameter int REPEAT_MS     = 100
`endif
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       btn_mode_i,
    input  logic       btn_up_i,
    input  logic       btn_down_i,
    input  logic [4:0] cur_hour_i,
    input  logic [5:0] cur_min_i,
    input  logic [5:0] cur_sec_i,
    output logic [4:0] hour_set_o,
    output logic [5:0] min_set_o,
    output logic [5:0] sec_set_o,
    output logic       timeset_o,
    output logic       editing_o,
    output logic [1:0] field_o
);

    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DB_W   = $clog2(DEBOUNCE_MS + 1);
    localparam int TO_W   = $clog2(TIMEOUT_MS + 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_EDIT_HR  = 3'd1,
        ST_EDIT_MIN = 3'd2,
        ST_EDIT_SEC = 3'd3,
        ST_COMMIT   = 3'd4
    } state_t;

    state_t            state_r, next_state_s;
    logic [TICK_W-1:0] tick_cnt_r;
    logic              tick_s;
    logic [2:0]        btn_raw_s, sync1_r, sync2_r;
    logic [2:0]        db_level_r, db_level_d_r, press_s;
    logic [DB_W-1:0]   db_cnt_r [3];
    logic [TO_W-1:0]   to_cnt_r;
    logic              editing_s, mode_ev_s, step_up_s, step_dn_s, any_press_s;
    logic              rpt_step_s, timeout_s;
    logic [4:0]        hour_nx_s;
    logic [5:0]        min_nx_s, sec_nx_s;

    function automatic logic [4:0] hr_inc(input logic [4:0] h);
        if ((h >= 5'd12) || (h == 5'd0)) hr_inc = 5'd1;
        else                             hr_inc = h + 5'd1;
    endfunction

    function automatic logic [4:0] hr_dec(input logic [4:0] h);
        if ((h <= 5'd1) || (h > 5'd12)) hr_dec = 5'd12;
        else                            hr_dec = h - 5'd1;
    endfunction

    function automatic logic [4:0] hr_load(input logic [4:0] h);
        if ((h == 5'd0) || (h > 5'd12)) hr_load = 5'd12;
        else                            hr_load = h;
    endfunction

    function automatic logic [5:0] sx_inc(input logic [5:0] v);
        if (v >= 6'd59) sx_inc = 6'd0;
        else            sx_inc = v + 6'd1;
    endfunction

    function automatic logic [5:0] sx_dec(input logic [5:0] v);
        if ((v == 6'd0) || (v > 6'd59)) sx_dec = 6'd59;
        else                            sx_dec = v - 6'd1;
    endfunction

    function automatic logic [5:0] sx_load(input logic [5:0] v);
        if (v > 6'd59) sx_load = 6'd59;
        else           sx_load = v;
    endfunction

    function automatic logic [1:0] field_of(input state_t st);
        case (st)
            ST_EDIT_HR:  field_of = 2'd1;
            ST_EDIT_MIN: field_of = 2'd2;
            ST_EDIT_SEC: field_of = 2'd3;
            default:     field_of = 2'd0;
        endcase
    endfunction

    assign btn_raw_s = {btn_down_i, btn_up_i, btn_mode_i};
    assign tick_s    = (tick_cnt_r == TICK_W'(TICK_DIV - 1));
    assign editing_s = (state_r == ST_EDIT_HR) || (state_r == ST_EDIT_MIN) || (state_r == ST_EDIT_SEC);

    // 1 ms tick prescaler
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)     tick_cnt_r <= '0;
        else if (tick_s) tick_cnt_r <= '0;
        else             tick_cnt_r <= tick_cnt_r + TICK_W'(1);
    end

    // Two-flop synchronizers for the raw buttons
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            sync1_r <= 3'b000;
            sync2_r <= 3'b000;
        end else begin
            sync1_r <= btn_raw_s;
            sync2_r <= sync1_r;
        end
    end

    // Debounce: any cycle agreeing with the accepted level restarts the stability count
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            db_level_r   <= 3'b000;
            db_level_d_r <= 3'b000;
            for (int i = 0; i < 3; i++) db_cnt_r[i] <= '0;
        end else begin
            db_level_d_r <= db_level_r;
            for (int i = 0; i < 3; i++) begin
                if (sync2_r[i] == db_level_r[i]) begin
                    db_cnt_r[i] <= '0;
                end else if (tick_s) begin
                    if (db_cnt_r[i] == DB_W'(DEBOUNCE_MS - 1)) begin
                        db_level_r[i] <= sync2_r[i];
                        db_cnt_r[i]   <= '0;
                    end else begin
                        db_cnt_r[i] <= db_cnt_r[i] + DB_W'(1);
                    end
                end
            end
        end
    end

    assign press_s     = db_level_r & ~db_level_d_r;
    assign any_press_s = |press_s;
    assign mode_ev_s   = press_s[0];

`ifdef AUTOREPEAT_EN
    localparam int RPT_MAX = (REPEAT_DLY_MS > REPEAT_MS) ? REPEAT_DLY_MS : REPEAT_MS;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);

    logic [RPT_W-1:0] rpt_cnt_r;
    logic             rpt_armed_r, rpt_hold_s;

    assign rpt_hold_s = editing_s & (db_level_r[1] ^ db_level_r[2]);
    assign rpt_step_s = rpt_hold_s & tick_s & ~(|press_s[2:1]) &
                        (rpt_armed_r ? (rpt_cnt_r == RPT_W'(REPEAT_MS - 1))
                                     : (rpt_cnt_r == RPT_W'(REPEAT_DLY_MS - 1)));

    // Hold timer: initial delay first, then the repeat period
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rpt_cnt_r   <= '0;
            rpt_armed_r <= 1'b0;
        end else if (!rpt_hold_s || (|press_s[2:1])) begin
            rpt_cnt_r   <= '0;
            rpt_armed_r <= 1'b0;
        end else if (tick_s) begin
            if (rpt_step_s) begin
                rpt_cnt_r   <= '0;
                rpt_armed_r <= 1'b1;
            end else begin
                rpt_cnt_r <= rpt_cnt_r + RPT_W'(1);
            end
        end
    end
`else
    assign rpt_step_s = 1'b0;
`endif

    // MODE pre-empts any step in the same cycle; simultaneous UP+DOWN cancel
    assign step_up_s = ~mode_ev_s & ((press_s[1] & ~press_s[2]) | (rpt_step_s & db_level_r[1]));
    assign step_dn_s = ~mode_ev_s & ((press_s[2] & ~press_s[1]) | (rpt_step_s & db_level_r[2]));
    assign timeout_s = editing_s & tick_s & ~any_press_s & ~rpt_step_s &
                       (to_cnt_r == TO_W'(TIMEOUT_MS - 1));

    // Edit inactivity timer, restarted by every accepted press or repeat step
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)                                   to_cnt_r <= '0;
        else if (!editing_s || any_press_s || rpt_step_s) to_cnt_r <= '0;
        else if (tick_s)                               to_cnt_r <= to_cnt_r + TO_W'(1);
    end

    // Next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (mode_ev_s) next_state_s = ST_EDIT_HR;
                else           next_state_s = ST_IDLE;
            end
            ST_EDIT_HR: begin
                if (mode_ev_s)      next_state_s = ST_EDIT_MIN;
                else if (timeout_s) next_state_s = ST_IDLE;
                else                next_state_s = ST_EDIT_HR;
            end
            ST_EDIT_MIN: begin
                if (mode_ev_s)      next_state_s = ST_EDIT_SEC;
                else if (timeout_s) next_state_s = ST_IDLE;
                else                next_state_s = ST_EDIT_MIN;
            end
            ST_EDIT_SEC: begin
                if (mode_ev_s)      next_state_s = ST_COMMIT;
                else if (timeout_s) next_state_s = ST_IDLE;
                else                next_state_s = ST_EDIT_SEC;
            end
            ST_COMMIT: next_state_s = ST_IDLE;
            default:   next_state_s = ST_IDLE;
        endcase
    end

    // Shadow register next values: capture on entry, step the active field otherwise
    always_comb begin
        hour_nx_s = hour_set_o;
        min_nx_s  = min_set_o;
        sec_nx_s  = sec_set_o;
        if ((state_r == ST_IDLE) && mode_ev_s) begin
            hour_nx_s = hr_load(cur_hour_i);
            min_nx_s  = sx_load(cur_min_i);
            sec_nx_s  = sx_load(cur_sec_i);
        end else if (step_up_s || step_dn_s) begin
            case (state_r)
                ST_EDIT_HR:  hour_nx_s = step_up_s ? hr_inc(hour_set_o) : hr_dec(hour_set_o);
                ST_EDIT_MIN: min_nx_s  = step_up_s ? sx_inc(min_set_o)  : sx_dec(min_set_o);
                ST_EDIT_SEC: sec_nx_s  = step_up_s ? sx_inc(sec_set_o)  : sx_dec(sec_set_o);
                default: begin
                    hour_nx_s = hour_set_o;
                    min_nx_s  = min_set_o;
                    sec_nx_s  = sec_set_o;
                end
            endcase
        end else begin
            hour_nx_s = hour_set_o;
            min_nx_s  = min_set_o;
            sec_nx_s  = sec_set_o;
        end
    end

    // State, shadows and registered status outputs
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r    <= ST_IDLE;
            hour_set_o <= 5'd12;
            min_set_o  <= 6'd0;
            sec_set_o  <= 6'd0;
            timeset_o  <= 1'b0;
            editing_o  <= 1'b0;
            field_o    <= 2'd0;
        end else begin
            state_r    <= next_state_s;
            hour_set_o <= hour_nx_s;
            min_set_o  <= min_nx_s;
            sec_set_o  <= sec_nx_s;
            timeset_o  <= (next_state_s == ST_COMMIT);
            editing_o  <= (field_of(next_state_s) != 2'd0);
            field_o    <= field_of(next_state_s);
        end
    end

endmodule

// File: tb/tb_time_set_ctrl.sv
// Self-checking bench for time_set_ctrl: a field/shadow model updated per button action, compared every settled cycle.
// Build with AUTOREPEAT_EN defined to exercise hold-to-repeat.
module tb_time_set_ctrl;

    localparam int HOLD_MS    = 18;
    localparam int RPT_DLY_MS = 8;
    localparam int RPT_MS     = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_mode, btn_up, btn_down;
    logic [4:0] cur_hour;
    logic [5:0] cur_min, cur_sec;
    logic [4:0] hour_set;
    logic [5:0] min_set, sec_set;
    logic       timeset, editing;
    logic [1:0] field;

    // model of the user-visible state
    int m_field, m_hour, m_min, m_sec, m_commits;
    int mc_hour, mc_min, mc_sec;

    // check controls
    logic chk_en = 1'b0, lit_en = 1'b0, fin_en = 1'b0;
    int   lit_hour, lit_min, lit_sec, lit_field, lit_edit;
    int   checks = 0, errors = 0;
    int   ts_cycles = 0, ts_pulses = 0;
    logic ts_prev = 1'b0;

    always #5 clk = ~clk;

    time_set_ctrl #(
        .TICK_DIV(4), .DEBOUNCE_MS(2), .TIMEOUT_MS(50)
`ifdef AUTOREPEAT_EN
        , .REPEAT_DLY_MS(RPT_DLY_MS), .REPEAT_MS(RPT_MS)
`endif
    ) dut (
        .clk_i(clk), .reset_i(rst),
        .btn_mode_i(btn_mode), .btn_up_i(btn_up), .btn_down_i(btn_down),
        .cur_hour_i(cur_hour), .cur_min_i(cur_min), .cur_sec_i(cur_sec),
        .hour_set_o(hour_set), .min_set_o(min_set), .sec_set_o(sec_set),
        .timeset_o(timeset), .editing_o(editing), .field_o(field)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // single compare process: reset values, model, literal pins, commit strobes
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rst_hour", 32'(hour_set), 32'd12);
                chk("rst_min", 32'(min_set), 32'd0);
                chk("rst_sec", 32'(sec_set), 32'd0);
                chk("rst_timeset", 32'(timeset), 32'd0);
                chk("rst_editing", 32'(editing), 32'd0);
                chk("rst_field", 32'(field), 32'd0);
            end else begin
                if (timeset === 1'b1) begin
                    ts_cycles++;
                    if (!ts_prev) ts_pulses++;
                    chk("commit_hour", 32'(hour_set), 32'(mc_hour));
                    chk("commit_min", 32'(min_set), 32'(mc_min));
                    chk("commit_sec", 32'(sec_set), 32'(mc_sec));
                end
                if (chk_en) begin
                    chk("hour", 32'(hour_set), 32'(m_hour));
                    chk("min", 32'(min_set), 32'(m_min));
                    chk("sec", 32'(sec_set), 32'(m_sec));
                    chk("field", 32'(field), 32'(m_field));
                    chk("editing", 32'(editing), 32'(m_field != 0));
                    chk("timeset_idle", 32'(timeset), 32'd0);
                end
                if (lit_en) begin
                    chk("lit_hour", 32'(hour_set), 32'(lit_hour));
                    chk("lit_min", 32'(min_set), 32'(lit_min));
                    chk("lit_sec", 32'(sec_set), 32'(lit_sec));
                    chk("lit_field", 32'(field), 32'(lit_field));
                    chk("lit_editing", 32'(editing), 32'(lit_edit));
                end
                if (fin_en) begin
                    chk("commit_pulses", 32'(ts_pulses), 32'(m_commits));
                    chk("commit_cycles", 32'(ts_cycles), 32'(m_commits));
                end
            end
            ts_prev = (rst === 1'b0) && (timeset === 1'b1);
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    function automatic int wrap12(input int h, input int d);
        return ((h - 1 + d + 120) % 12) + 1;
    endfunction

    function automatic int wrap60(input int v, input int d);
        return (v + d + 600) % 60;
    endfunction

    task automatic model_step(input int d);
        case (m_field)
            1:       m_hour = wrap12(m_hour, d);
            2:       m_min  = wrap60(m_min, d);
            3:       m_sec  = wrap60(m_sec, d);
            default: ;
        endcase
    endtask

    task automatic model_apply(input logic m, input logic u, input logic d);
        if (m) begin
            if (m_field == 0) begin
                m_hour  = (int'(cur_hour) % 12 == 0) ? 12 : int'(cur_hour);
                m_min   = int'(cur_min);
                m_sec   = int'(cur_sec);
                m_field = 1;
            end else if (m_field == 3) begin
                m_commits++;
                mc_hour = m_hour; mc_min = m_min; mc_sec = m_sec;
                m_field = 0;
            end else begin
                m_field++;
            end
        end else if (u && !d) begin
            model_step(1);
        end else if (d && !u) begin
            model_step(-1);
        end
    endtask

    task automatic press(input logic m, input logic u, input logic d);
        chk_en = 1'b0;
        btn_mode = m; btn_up = u; btn_down = d;
        model_apply(m, u, d);
        step(24);
        btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
        chk_en = 1'b1;
        step(24);
    endtask

    task automatic lit(input int h, input int mi, input int s, input int f, input int e);
        lit_hour = h; lit_min = mi; lit_sec = s; lit_field = f; lit_edit = e;
        lit_en = 1'b1;
        step(1);
        lit_en = 1'b0;
    endtask

    task automatic set_cur(input int h, input int mi, input int s);
        cur_hour = 5'(h); cur_min = 6'(mi); cur_sec = 6'(s);
    endtask

    initial begin
        int n_rep;
        rst = 1'b1;
        btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
        set_cur(11, 59, 30);
        m_field = 0; m_hour = 12; m_min = 0; m_sec = 0; m_commits = 0;
        mc_hour = 0; mc_min = 0; mc_sec = 0;
        step(3);
        rst = 1'b0;
        chk_en = 1'b1;
        step(8);
        lit(12, 0, 0, 0, 0);

        // UP in IDLE is ignored
        press(1'b0, 1'b1, 1'b0);
        // hour entry and wrap
        press(1'b1, 1'b0, 1'b0);
        lit(11, 59, 30, 1, 1);
        press(1'b0, 1'b1, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        lit(1, 59, 30, 1, 1);
        press(1'b0, 1'b0, 1'b1);
        lit(12, 59, 30, 1, 1);

        // bounce: 6 cycles of toggling never reaches a stable debounced level
        for (int i = 0; i < 6; i++) begin
            btn_up = ~btn_up;
            step(1);
        end
        btn_up = 1'b0;
        step(24);

        // MODE wins over a simultaneous UP; UP+DOWN together do nothing
        press(1'b1, 1'b1, 1'b0);
        lit(12, 59, 30, 2, 1);
        press(1'b0, 1'b1, 1'b1);
        press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0);

        // full edit and commit from 12:59:00 to 12:00:59
        set_cur(12, 59, 0);
        press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b0, 1'b1);
        press(1'b1, 1'b0, 1'b0);
        lit(12, 0, 59, 0, 0);

        // hour 0 loads as 12; then timeout in EDIT_MIN keeps edited shadows
        set_cur(0, 5, 7);
        press(1'b1, 1'b0, 1'b0);
        lit(12, 5, 7, 1, 1);
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        step(120);
        chk_en = 1'b0;
        step(100);
        m_field = 0;
        chk_en = 1'b1;
        step(4);
        lit(12, 6, 7, 0, 0);

        // held UP in EDIT_MIN
        set_cur(3, 10, 20);
        press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        chk_en = 1'b0;
        btn_up = 1'b1;
        step(HOLD_MS * 4);
        btn_up = 1'b0;
        step(30);
`ifdef AUTOREPEAT_EN
        n_rep = 1 + (HOLD_MS - RPT_DLY_MS) / RPT_MS;
`else
        n_rep = 0;
`endif
        m_min = wrap60(m_min, 1 + n_rep);
        chk_en = 1'b1;
        step(2);
`ifdef AUTOREPEAT_EN
        lit(3, 14, 20, 2, 1);
`else
        lit(3, 11, 20, 2, 1);
`endif

        // reset in EDIT_SEC: straight to IDLE with no commit
        press(1'b1, 1'b0, 1'b0);
        chk_en = 1'b0;
        rst = 1'b1;
        step(3);
        m_field = 0; m_hour = 12; m_min = 0; m_sec = 0;
        rst = 1'b0;
        chk_en = 1'b1;
        step(30);

        fin_en = 1'b1;
        step(1);
        fin_en = 1'b0;
        chk_en = 1'b0;
        step(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
